switch_allocator: RTL
=====================

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter PORTS, default 5: number of router input ports and output ports (indices 4..0).
REQ-002 Parameter PACKET_FLITS, default 8: flits per packet (packet_size 32 / flit_size 4).
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port req  input  PORTS*PORTS: bits [5i+4:5i] are input i's one-hot request_vector; bit 5i+o means input i requests output o.
REQ-006 Port dest_full  input  PORTS: bit o high means downstream of output o cannot accept a flit this cycle.
REQ-007 Port grant  output  PORTS*PORTS: registered; bit 5i+o means output o is currently allocated to input i.
REQ-008 Port out_sel  output  3*PORTS: bits [3o+2:3o] give the input index driving output o's crossbar mux; registered.
REQ-009 Port out_valid  output  PORTS: bit o high means a flit crosses output o this cycle.
REQ-010 Port stall  output  PORTS: bit i high means input i shall hold its current flit this cycle.

Function
REQ-011 Each output o shall have an independent FSM with states IDLE and BUSY, a round-robin pointer ptr[o] (0..4) and a flit counter cnt[o] of width ceil(log2(PACKET_FLITS+1)).
REQ-012 An input's request shall be valid only when its 5-bit field is exactly one-hot; zero or multi-hot fields are ignored entirely, with no grant and stall low.
REQ-013 In IDLE with dest_full[o] low and at least one valid request for o, the FSM shall pick the first requesting input searching ptr[o], ptr[o]+1, ... modulo PORTS, and move to BUSY on the next edge.
REQ-014 In IDLE with dest_full[o] high, no grant shall be issued and the FSM shall remain IDLE.
REQ-015 On entering BUSY: set grant bit 5i+o and out_sel[o]=i, clear cnt[o], and set ptr[o]=(i+1) mod PORTS.
REQ-016 Grant latency: a request first valid in cycle t against an IDLE, non-full output yields grant in cycle t+1.
REQ-017 out_valid[o] = BUSY and not dest_full[o], combinational.
REQ-018 cnt[o] increments on every edge where out_valid[o] is high.
REQ-019 The BUSY to IDLE transition shall occur on the edge where out_valid[o] is high and cnt[o]==PACKET_FLITS-1; grant and out_sel clear at that edge.
REQ-020 No new grant shall be issued for o in the cycle it returns to IDLE; there is exactly one IDLE bubble cycle between packets.
REQ-021 In BUSY, changes or withdrawal of the granted input's request shall not affect grant, cnt or ptr; the packet completes.
REQ-022 stall[i] shall be high when input i has a valid request and is either not granted its requested output or is granted but dest_full of that output is high; otherwise low.
REQ-023 Requests of different inputs to different outputs shall be granted independently in the same cycle.
REQ-024 At most one grant bit per output and one per input shall be set at any time.

Reset
REQ-025 On a rising edge with reset high, all FSMs shall go to IDLE, with ptr=0, cnt=0, grant=0 and out_sel=0; this applies mid-packet as well.
REQ-026 While reset is high, out_valid=0 and stall=0.
REQ-027 The first grant after reset shall follow REQ-016 timing, measured from the first cycle with reset low.

Verification
REQ-028 Single request: req bit 5*2+0 set at t with dest_full=0 -> grant[10]=1 and out_sel[2:0]=2 at t+1; out_valid[0]=1 for 8 cycles; grant clears after the 8th; ptr[0]=3.
REQ-029 Contention: inputs 1, 3 and 4 all request output 2 continuously from reset -> grants in order 1, 3, 4, 1, each for 8 transfers, with one idle cycle between grants; stall high for the waiting inputs.
REQ-030 Backpressure: during BUSY, dest_full[o] high for 3 cycles -> out_valid[o]=0, cnt frozen, stall[i]=1 during those cycles; release occurs 3 cycles later than without backpressure.
REQ-031 Illegal request: input 0 field 5'b00110 -> no grant and stall[0]=0; a concurrent legal request from input 1 to output 1 is granted at t+1.
REQ-032 Reset mid-packet: reset at cnt=4 -> next cycle grant=0, out_valid=0, and the pending request is re-granted from ptr=0 one cycle after reset deasserts.
REQ-033 Parallel traffic: input i requests output (i+1) mod 5 for all i -> all 5 grants are asserted in the same cycle and out_valid=5'b11111.

Source files
------------

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator for a PORTSxPORTS wormhole router.
// Each output stays locked to one input for PACKET_FLITS transfers, then idles one cycle.
module switch_allocator #(
  parameter int PORTS        = 5,
  parameter int PACKET_FLITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PORTS*PORTS-1:0]   req,
  input  logic [PORTS-1:0]         dest_full,
  output logic [PORTS*PORTS-1:0]   grant,
  output logic [3*PORTS-1:0]       out_sel,
  output logic [PORTS-1:0]         out_valid,
  output logic [PORTS-1:0]         stall
);

  localparam int CNT_W = $clog2(PACKET_FLITS + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q [PORTS];
  state_t             state_d [PORTS];
  logic [2:0]         ptr_q   [PORTS];
  logic [2:0]         ptr_d   [PORTS];
  logic [CNT_W-1:0]   cnt_q   [PORTS];
  logic [CNT_W-1:0]   cnt_d   [PORTS];
  logic [PORTS*PORTS-1:0] grant_d;
  logic [3*PORTS-1:0]     sel_d;
  logic [PORTS-1:0]       req_valid;
  logic [PORTS-1:0]       in_granted;

  // An input already holding an output is kept out of arbitration elsewhere,
  // so a request change mid-packet can never give it a second grant.
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      req_valid[i]  = $onehot(req[i*PORTS +: PORTS]);
      in_granted[i] = |grant[i*PORTS +: PORTS];
    end
  end

  always_comb begin
    for (int o = 0; o < PORTS; o++) begin
      out_valid[o] = !reset && (state_q[o] == BUSY) && !dest_full[o];
    end
  end

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      stall[i] = !reset && req_valid[i] &&
                 !(|(grant[i*PORTS +: PORTS] & req[i*PORTS +: PORTS] & ~dest_full));
    end
  end

  always_comb begin
    logic found;
    int   pick;
    int   cand;
    found   = 1'b0;
    pick    = 0;
    cand    = 0;
    grant_d = grant;
    sel_d   = out_sel;
    for (int o = 0; o < PORTS; o++) begin
      state_d[o] = state_q[o];
      ptr_d[o]   = ptr_q[o];
      cnt_d[o]   = cnt_q[o];
      case (state_q[o])
        IDLE: begin
          if (!dest_full[o]) begin
            found = 1'b0;
            pick  = 0;
            for (int k = 0; k < PORTS; k++) begin
              cand = int'(ptr_q[o]) + k;
              if (cand >= PORTS) cand = cand - PORTS;
              if (!found && req_valid[cand] && req[cand*PORTS + o] && !in_granted[cand]) begin
                found = 1'b1;
                pick  = cand;
              end
            end
            if (found) begin
              state_d[o]             = BUSY;
              grant_d[pick*PORTS + o] = 1'b1;
              sel_d[3*o +: 3]        = 3'(pick);
              cnt_d[o]               = '0;
              ptr_d[o]               = (pick + 1 == PORTS) ? 3'd0 : 3'(pick + 1);
            end
          end
        end
        BUSY: begin
          if (out_valid[o]) begin
            cnt_d[o] = cnt_q[o] + 1'b1;
            if (cnt_q[o] == CNT_W'(PACKET_FLITS - 1)) begin
              state_d[o]      = IDLE;
              sel_d[3*o +: 3] = 3'd0;
              for (int i = 0; i < PORTS; i++) begin
                grant_d[i*PORTS + o] = 1'b0;
              end
            end
          end
        end
        default: state_d[o] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int o = 0; o < PORTS; o++) begin
        state_q[o] <= IDLE;
        ptr_q[o]   <= '0;
        cnt_q[o]   <= '0;
      end
      grant   <= '0;
      out_sel <= '0;
    end else begin
      for (int o = 0; o < PORTS; o++) begin
        state_q[o] <= state_d[o];
        ptr_q[o]   <= ptr_d[o];
        cnt_q[o]   <= cnt_d[o];
      end
      grant   <= grant_d;
      out_sel <= sel_d;
    end
  end

endmodule
